// File: rtl/pkt_ingress_fifo.sv
// Store-and-forward AXI-Stream packet FIFO ahead of the packet filter.
// Packets are released only once complete; packets that would overflow are dropped whole and counted.
module pkt_ingress_fifo #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int DEPTH_LOG2           = 6
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic [31:0]                       drop_cnt,
  output logic [31:0]                       pkt_cnt
);

  localparam int DW    = C_S_AXIS_DATA_WIDTH;
  localparam int UW    = C_S_AXIS_TUSER_WIDTH;
  localparam int KW    = DW / 8;
  localparam int EW    = 1 + KW + UW + DW;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] PTR_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] DROP  = 2'd2;

  logic [EW-1:0]   mem [DEPTH];
  logic [EW-1:0]   rd_entry;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   commit_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [1:0]      state;
  logic            full;
  logic            avail;
  logic            wr_beat;
  logic            store;
  logic            rd_beat;
  logic            rd_last;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign full    = (wr_ptr - rd_ptr) == PTR_FULL;
  assign avail   = (commit_ptr != rd_ptr);
  assign wr_beat = s_axis_tvalid && s_axis_tready;
  assign store   = wr_beat && (state != DROP) && !full;
  assign rd_beat = m_axis_tvalid && m_axis_tready;

  // Storage has no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (store) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tuser, s_axis_tdata};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      commit_ptr    <= '0;
      rd_ptr        <= '0;
      state         <= IDLE;
      s_axis_tready <= 1'b0;
      drop_cnt      <= '0;
      pkt_cnt       <= '0;
    end else begin
      s_axis_tready <= 1'b1;
      if (rd_beat) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (wr_beat) begin
        case (state)
          IDLE, WRITE: begin
            if (full) begin
              // Overflow discards everything written for this packet so far.
              wr_ptr <= commit_ptr;
              if (s_axis_tlast) begin
                drop_cnt <= sat_inc(drop_cnt);
                state    <= IDLE;
              end else begin
                state <= DROP;
              end
            end else begin
              wr_ptr <= wr_ptr + PTR_ONE;
              if (s_axis_tlast) begin
                commit_ptr <= wr_ptr + PTR_ONE;
                pkt_cnt    <= sat_inc(pkt_cnt);
                state      <= IDLE;
              end else begin
                state <= WRITE;
              end
            end
          end
          DROP: begin
            if (s_axis_tlast) begin
              drop_cnt <= sat_inc(drop_cnt);
              state    <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // First-word-fall-through read of the committed region.
  assign rd_entry = mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign {rd_last, m_axis_tkeep, m_axis_tuser, m_axis_tdata} = rd_entry;
  assign m_axis_tvalid = avail;
  assign m_axis_tlast  = avail & rd_last;

endmodule
